// File: rtl/clint_vec.sv
// -----------------------------------------------------------------------------
// clint_vec
//
// Purpose:
//   Core-local interrupt controller. It arbitrates synchronous exceptions
//   (ECALL/EBREAK), MRET and NUM_IRQ individually maskable external interrupt
//   lines under a fixed priority. On a trap it runs the CSR write sequence
//   mepc -> mstatus -> mcause and then redirects the execute stage to a
//   direct or vectored handler. On MRET it restores MIE from MPIE and
//   redirects to mepc. The line that was taken gets a one-cycle acknowledge.
//
// Parameters:
//   NUM_IRQ        number of external interrupt lines (1..16)
//   VECTORED_EN    1: honour mtvec MODE=01 for interrupts, 0: always direct
//   IRQ_CODE_BASE  mcause exception code of line 0 (line k -> base+k)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   irq_i, irq_en_i     level interrupt requests and per-line enables
//   global_int_en_i     mstatus.MIE
//   inst_i, inst_addr_i instruction currently in decode and its address
//   jump_flag_i/addr_i  pending jump resolved in execute
//   div_started_i       divider busy
//   csr_mtvec/mepc/mstatus  current CSR values from the CSR file
//   hold_flag_o         pipeline hold request
//   we_o/waddr_o/data_o CSR write port (address/data are zero when idle)
//   int_assert_o        one-cycle redirect pulse, target on int_addr_o
//   irq_ack_o           one-hot acknowledge of the external line taken
// -----------------------------------------------------------------------------
module clint_vec #(
  parameter int NUM_IRQ       = 8,
  parameter int VECTORED_EN   = 1,
  parameter int IRQ_CODE_BASE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               global_int_en_i,
  input  logic [31:0]        inst_i,
  input  logic [31:0]        inst_addr_i,
  input  logic               jump_flag_i,
  input  logic [31:0]        jump_addr_i,
  input  logic               div_started_i,
  input  logic [31:0]        csr_mtvec,
  input  logic [31:0]        csr_mepc,
  input  logic [31:0]        csr_mstatus,
  output logic               hold_flag_o,
  output logic               we_o,
  output logic [31:0]        waddr_o,
  output logic [31:0]        data_o,
  output logic               int_assert_o,
  output logic [31:0]        int_addr_o,
  output logic [NUM_IRQ-1:0] irq_ack_o
);

  // Width of the winning-line index; a single line still gets one bit.
  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CSR_MSTATUS_ADDR = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC_ADDR    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE_ADDR  = 32'h0000_0342;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEPC    = 3'd1,
    S_MSTATUS = 3'd2,
    S_MCAUSE  = 3'd3,
    S_MRET    = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Trap context captured when leaving IDLE so later input changes cannot
  // disturb a sequence already in flight.
  logic [31:0]     epc_q, epc_d;
  logic [31:0]     cause_q, cause_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            async_q, async_d;

  // Registered outputs.
  logic               we_q, we_d;
  logic [31:0]        waddr_q, waddr_d;
  logic [31:0]        data_q, data_d;
  logic               int_assert_q, int_assert_d;
  logic [31:0]        int_addr_q, int_addr_d;
  logic [NUM_IRQ-1:0] irq_ack_q, irq_ack_d;

  // Decode and event detection signals.
  logic               is_ecall;
  logic               is_ebreak;
  logic               is_mret;
  logic               is_sync_inst;
  logic [NUM_IRQ-1:0] pend;
  logic [ID_W-1:0]    win_id;
  logic               in_idle;
  logic               ev_sync;
  logic               ev_async;
  logic               ev_mret;
  logic               ev_any;

  // Handler address computation.
  logic [31:0] tvec_base;
  logic        use_vector;
  logic [31:0] vector_off;
  logic [31:0] entry_target;

  // mstatus images for trap entry and MRET.
  logic [31:0] mstatus_entry;
  logic [31:0] mstatus_mret;

  // Instruction decode and pending-line mask.
  always_comb begin
    is_ecall     = (inst_i == INST_ECALL);
    is_ebreak    = (inst_i == INST_EBREAK);
    is_mret      = (inst_i == INST_MRET);
    is_sync_inst = is_ecall | is_ebreak;
    pend         = irq_i & irq_en_i;
  end

  // Fixed priority among the external lines: the lowest index wins, so the
  // scan runs from the top down and the last hit overrides.
  always_comb begin
    win_id = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (pend[k]) begin
        win_id = ID_W'(k);
      end
    end
  end

  // Event priority in IDLE. An ECALL/EBREAK stalled behind a busy divider
  // blocks everything, including interrupts, until the divider finishes,
  // so the exception is never reordered behind an interrupt.
  always_comb begin
    in_idle  = (state_q == S_IDLE);
    ev_sync  = in_idle & is_sync_inst & ~div_started_i;
    ev_async = in_idle & ~is_sync_inst & (|pend) & global_int_en_i;
    ev_mret  = in_idle & ~is_sync_inst & ~ev_async & is_mret;
    ev_any   = ev_sync | ev_async | ev_mret;
  end

  // Handler address: vectored only for interrupts when the mode bits ask for
  // it and the feature is built in; exceptions always go to the base.
  always_comb begin
    tvec_base    = {csr_mtvec[31:2], 2'b00};
    use_vector   = (VECTORED_EN != 0) && async_q && (csr_mtvec[1:0] == 2'b01);
    vector_off   = (32'(IRQ_CODE_BASE) + 32'(id_q)) << 2;
    entry_target = use_vector ? (tvec_base + vector_off) : tvec_base;
  end

  // Trap entry saves MIE into MPIE and clears MIE; MRET restores MIE from
  // MPIE and sets MPIE. All other mstatus bits pass through unchanged.
  always_comb begin
    mstatus_entry = (csr_mstatus & ~32'h0000_0088) | {24'b0, csr_mstatus[3], 7'b0};
    mstatus_mret  = (csr_mstatus & ~32'h0000_0088) | {24'b0, 1'b1, 3'b0, csr_mstatus[7], 3'b0};
  end

  // Next-state, context capture and registered output values. Every output
  // defaults to zero so each pulse lasts exactly one cycle and the write
  // address/data are clean whenever no write is in progress.
  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    id_d         = id_q;
    async_d      = async_q;
    we_d         = 1'b0;
    waddr_d      = 32'h0;
    data_d       = 32'h0;
    int_assert_d = 1'b0;
    int_addr_d   = 32'h0;
    irq_ack_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (ev_sync) begin
          state_d = S_MEPC;
          epc_d   = jump_flag_i ? (jump_addr_i - 32'd4) : inst_addr_i;
          cause_d = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
          id_d    = '0;
          async_d = 1'b0;
        end else if (ev_async) begin
          // A taken jump is the next instruction to execute; otherwise a
          // busy divider means the divide must be replayed from one back.
          state_d = S_MEPC;
          if (jump_flag_i) begin
            epc_d = jump_addr_i;
          end else if (div_started_i) begin
            epc_d = inst_addr_i - 32'd4;
          end else begin
            epc_d = inst_addr_i;
          end
          cause_d = {1'b1, 31'(IRQ_CODE_BASE) + 31'(win_id)};
          id_d    = win_id;
          async_d = 1'b1;
        end else if (ev_mret) begin
          state_d = S_MRET;
        end
      end

      S_MEPC: begin
        state_d = S_MSTATUS;
        we_d    = 1'b1;
        waddr_d = CSR_MEPC_ADDR;
        data_d  = epc_q;
      end

      S_MSTATUS: begin
        state_d = S_MCAUSE;
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS_ADDR;
        data_d  = mstatus_entry;
      end

      S_MCAUSE: begin
        state_d      = S_IDLE;
        we_d         = 1'b1;
        waddr_d      = CSR_MCAUSE_ADDR;
        data_d       = cause_q;
        int_assert_d = 1'b1;
        int_addr_d   = entry_target;
        if (async_q) begin
          irq_ack_d = NUM_IRQ'(1) << id_q;
        end
      end

      S_MRET: begin
        state_d      = S_IDLE;
        we_d         = 1'b1;
        waddr_d      = CSR_MSTATUS_ADDR;
        data_d       = mstatus_mret;
        int_assert_d = 1'b1;
        int_addr_d   = csr_mepc;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, context and output registers. Reset clears everything so no
  // partial CSR write can leak out after a reset mid-sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      epc_q        <= 32'h0;
      cause_q      <= 32'h0;
      id_q         <= '0;
      async_q      <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= 32'h0;
      data_q       <= 32'h0;
      int_assert_q <= 1'b0;
      int_addr_q   <= 32'h0;
      irq_ack_q    <= '0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      id_q         <= id_d;
      async_q      <= async_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      data_q       <= data_d;
      int_assert_q <= int_assert_d;
      int_addr_q   <= int_addr_d;
      irq_ack_q    <= irq_ack_d;
    end
  end

  // The hold is raised combinationally on the detecting cycle so the
  // pipeline freezes before the event instruction advances, and it is kept
  // through the redirect cycle.
  always_comb begin
    hold_flag_o  = ev_any | (state_q != S_IDLE) | int_assert_q;
    we_o         = we_q;
    waddr_o      = waddr_q;
    data_o       = data_q;
    int_assert_o = int_assert_q;
    int_addr_o   = int_addr_q;
    irq_ack_o    = irq_ack_q;
  end

endmodule

// File: tb/tb_clint_vec.sv
// -----------------------------------------------------------------------------
// tb_clint_vec
//
// Self-checking bench for clint_vec (default parameters: 8 lines, vectoring
// built in, interrupt code base 16). Each transaction presents one set of
// inputs for a single cycle, then idles the request inputs and follows the
// outputs for five cycles against a trap model derived from the priority,
// epc, cause and mstatus rules of the controller.
// -----------------------------------------------------------------------------
module tb_clint_vec;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [7:0]  irq_i;
  logic [7:0]  irq_en_i;
  logic        global_int_en_i;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        div_started_i;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic [31:0] csr_mstatus;
  logic        hold_flag_o;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] data_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;
  logic [7:0]  irq_ack_o;

  int check_count;
  int pass_count;

  clint_vec #(
    .NUM_IRQ(8),
    .VECTORED_EN(1),
    .IRQ_CODE_BASE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .irq_i(irq_i),
    .irq_en_i(irq_en_i),
    .global_int_en_i(global_int_en_i),
    .inst_i(inst_i),
    .inst_addr_i(inst_addr_i),
    .jump_flag_i(jump_flag_i),
    .jump_addr_i(jump_addr_i),
    .div_started_i(div_started_i),
    .csr_mtvec(csr_mtvec),
    .csr_mepc(csr_mepc),
    .csr_mstatus(csr_mstatus),
    .hold_flag_o(hold_flag_o),
    .we_o(we_o),
    .waddr_o(waddr_o),
    .data_o(data_o),
    .int_assert_o(int_assert_o),
    .int_addr_o(int_addr_o),
    .irq_ack_o(irq_ack_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Waits for the next rising edge, then presents a full input set.
  task automatic applyStimulus(input logic [7:0] irq, input logic [7:0] en, input logic gie,
                               input logic [31:0] inst, input logic [31:0] iaddr,
                               input logic jf, input logic [31:0] ja, input logic div,
                               input logic [31:0] mtvec, input logic [31:0] mepc,
                               input logic [31:0] mstatus);
    @(posedge clk);
    #1;
    irq_i           = irq;
    irq_en_i        = en;
    global_int_en_i = gie;
    inst_i          = inst;
    inst_addr_i     = iaddr;
    jump_flag_i     = jf;
    jump_addr_i     = ja;
    div_started_i   = div;
    csr_mtvec       = mtvec;
    csr_mepc        = mepc;
    csr_mstatus     = mstatus;
  endtask

  // Removes every request; CSR values stay as the CSR file would hold them.
  task automatic clearRequests();
    irq_i           = '0;
    irq_en_i        = '0;
    global_int_en_i = 1'b0;
    inst_i          = NOP;
    jump_flag_i     = 1'b0;
    div_started_i   = 1'b0;
  endtask

  // Trap model: kind 0 = nothing, 1 = trap entry, 2 = return.
  task automatic predict(output int kind, output logic [31:0] epc, output logic [31:0] cause,
                         output logic [31:0] target, output logic [31:0] ms_w,
                         output logic [7:0] ack);
    logic       is_exc;
    logic [7:0] pend;
    logic [7:0] lowest;
    int         id;
    logic [31:0] base;
    is_exc = (inst_i == ECALL) || (inst_i == EBREAK);
    pend   = irq_i & irq_en_i;
    base   = csr_mtvec & ~32'd3;
    kind = 0; epc = 0; cause = 0; target = 0; ms_w = 0; ack = 0;
    if (is_exc) begin
      if (!div_started_i) begin
        kind   = 1;
        epc    = jump_flag_i ? jump_addr_i - 32'd4 : inst_addr_i;
        cause  = (inst_i == ECALL) ? 32'd11 : 32'd3;
        target = base;
      end
    end else if (pend != 0 && global_int_en_i) begin
      lowest = pend & (~pend + 8'd1);
      id = 0;
      for (int k = 0; k < 8; k++) if (lowest[k]) id = k;
      kind   = 1;
      epc    = jump_flag_i ? jump_addr_i : (div_started_i ? inst_addr_i - 32'd4 : inst_addr_i);
      cause  = 32'h8000_0000 + 32'(16 + id);
      ack    = lowest;
      target = (csr_mtvec[1:0] == 2'b01) ? base + 32'(4 * (16 + id)) : base;
    end else if (inst_i == MRET) begin
      kind   = 2;
      target = csr_mepc;
      ms_w   = (csr_mstatus & ~32'h88) | (((csr_mstatus >> 7) & 32'd1) << 3) | 32'h80;
    end
    if (kind == 1) begin
      ms_w = (csr_mstatus & ~32'h88) | (((csr_mstatus >> 3) & 32'd1) << 7);
    end
  endtask

  // Follows one transaction from the detecting cycle (cycle 0) to cycle 5.
  task automatic runTransaction(input string tag);
    int          kind;
    logic [31:0] epc, cause, target, ms_w;
    logic [7:0]  ack;
    logic        e_we, e_ia, e_hold;
    logic [31:0] e_addr, e_data, e_iaddr;
    logic [7:0]  e_ack;
    predict(kind, epc, cause, target, ms_w, ack);
    @(negedge clk);
    checkOutput({tag, ".hold_c0"}, 32'(hold_flag_o), 32'(kind != 0));
    checkOutput({tag, ".we_c0"}, 32'(we_o), 32'd0);
    @(posedge clk);
    #1;
    clearRequests();
    for (int c = 1; c <= 5; c++) begin
      e_we = 0; e_addr = 0; e_data = 0; e_ia = 0; e_iaddr = 0; e_ack = 0; e_hold = 0;
      if (kind == 1) begin
        e_hold = (c <= 4);
        if (c == 2) begin e_we = 1; e_addr = 32'h341; e_data = epc; end
        if (c == 3) begin e_we = 1; e_addr = 32'h300; e_data = ms_w; end
        if (c == 4) begin
          e_we = 1; e_addr = 32'h342; e_data = cause;
          e_ia = 1; e_iaddr = target; e_ack = ack;
        end
      end else if (kind == 2) begin
        e_hold = (c <= 2);
        if (c == 2) begin
          e_we = 1; e_addr = 32'h300; e_data = ms_w; e_ia = 1; e_iaddr = target;
        end
      end
      @(negedge clk);
      checkOutput($sformatf("%s.hold_c%0d", tag, c), 32'(hold_flag_o), 32'(e_hold));
      checkOutput($sformatf("%s.we_c%0d", tag, c), 32'(we_o), 32'(e_we));
      checkOutput($sformatf("%s.waddr_c%0d", tag, c), waddr_o, e_addr);
      checkOutput($sformatf("%s.data_c%0d", tag, c), data_o, e_data);
      checkOutput($sformatf("%s.assert_c%0d", tag, c), 32'(int_assert_o), 32'(e_ia));
      checkOutput($sformatf("%s.iaddr_c%0d", tag, c), int_addr_o, e_iaddr);
      checkOutput($sformatf("%s.ack_c%0d", tag, c), 32'(irq_ack_o), 32'(e_ack));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".hold"}, 32'(hold_flag_o), 32'd0);
    checkOutput({tag, ".we"}, 32'(we_o), 32'd0);
    checkOutput({tag, ".waddr"}, waddr_o, 32'd0);
    checkOutput({tag, ".data"}, data_o, 32'd0);
    checkOutput({tag, ".assert"}, 32'(int_assert_o), 32'd0);
    checkOutput({tag, ".iaddr"}, int_addr_o, 32'd0);
    checkOutput({tag, ".ack"}, 32'(irq_ack_o), 32'd0);
  endtask

  // Interrupt entry interrupted by a reset during the cycle the mepc write
  // is visible; nothing may come out afterwards.
  task automatic resetMidSequence();
    applyStimulus(8'h04, 8'hFF, 1'b1, NOP, 32'h300, 1'b1, 32'h400, 1'b0, 32'h8001, 32'h0, 32'h8);
    @(negedge clk);
    checkOutput("rstmid.hold_c0", 32'(hold_flag_o), 32'd1);
    @(posedge clk);
    #1;
    clearRequests();
    @(negedge clk);
    checkOutput("rstmid.we_c1", 32'(we_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid.we_c2", 32'(we_o), 32'd1);
    checkOutput("rstmid.waddr_c2", waddr_o, 32'h341);
    checkOutput("rstmid.mepc_c2", data_o, 32'h400);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      checkAllZero($sformatf("rstmid.c%0d", c));
    end
  endtask

  initial begin
    logic [31:0] r_inst;
    int          sel;
    check_count = 0;
    pass_count  = 0;
    rst         = 1'b1;
    csr_mtvec   = 32'h0;
    csr_mepc    = 32'h0;
    csr_mstatus = 32'h0;
    inst_addr_i = 32'h0;
    jump_addr_i = 32'h0;
    clearRequests();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("post_reset");

    $display("[TB] directed scenarios");
    applyStimulus(8'h00, 8'hFF, 1'b1, ECALL, 32'h100, 1'b0, 32'h0, 1'b0, 32'h8001, 32'h0, 32'h8);
    runTransaction("ecall");
    applyStimulus(8'h06, 8'hFF, 1'b1, NOP, 32'h120, 1'b0, 32'h0, 1'b0, 32'h8001, 32'h0, 32'h8);
    runTransaction("irq_line1_vec");
    applyStimulus(8'h06, 8'hFD, 1'b1, NOP, 32'h120, 1'b0, 32'h0, 1'b0, 32'h8001, 32'h0, 32'h8);
    runTransaction("irq_line2_vec");
    applyStimulus(8'h06, 8'hFD, 1'b1, NOP, 32'h120, 1'b0, 32'h0, 1'b0, 32'h8000, 32'h0, 32'h8);
    runTransaction("irq_line2_direct");
    applyStimulus(8'h01, 8'hFF, 1'b1, ECALL, 32'h140, 1'b0, 32'h0, 1'b1, 32'h8001, 32'h0, 32'h8);
    runTransaction("ecall_div_busy");
    applyStimulus(8'h01, 8'hFF, 1'b1, ECALL, 32'h140, 1'b0, 32'h0, 1'b0, 32'h8001, 32'h0, 32'h8);
    runTransaction("ecall_div_done");
    applyStimulus(8'h00, 8'h00, 1'b0, EBREAK, 32'h160, 1'b1, 32'h500, 1'b0, 32'h9000, 32'h0, 32'h0);
    runTransaction("ebreak_jump");
    applyStimulus(8'h00, 8'hFF, 1'b0, MRET, 32'h180, 1'b0, 32'h0, 1'b0, 32'h8001, 32'h200, 32'h80);
    runTransaction("mret");
    applyStimulus(8'h80, 8'h80, 1'b1, NOP, 32'h1C0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFD, 32'h0, 32'h8);
    runTransaction("irq_line7_wrap");
    resetMidSequence();

    $display("[TB] randomized scenarios");
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: r_inst = ECALL;
        1: r_inst = EBREAK;
        2: r_inst = MRET;
        3: r_inst = NOP;
        default: r_inst = $urandom;
      endcase
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), r_inst,
                    $urandom & ~32'd3, 1'($urandom_range(0, 1)), $urandom & ~32'd3,
                    ($urandom_range(0, 3) == 0), $urandom, $urandom, $urandom);
      runTransaction($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
